// File: rtl/mul_seq_if.sv
// Start/busy/done handshake bundle for the sequential multiplier.
// The requester drives start/x/y; the multiplier returns busy/done/out.
interface mul_seq_if #(
  parameter int W = 8
) ();
  logic           start;
  logic [W-1:0]   x;
  logic [W-1:0]   y;
  logic           busy;
  logic           done;
  logic [2*W-1:0] out;

  modport master (output start, x, y, input busy, done, out);
  modport slave  (input start, x, y, output busy, done, out);
endinterface

// File: rtl/mul_seq.sv
// Shift-add multiplier: W-bit x W-bit -> 2W-bit product, one multiplier bit per clock, W cycles latency.
// start is ignored while busy; out holds the last result. SIGNED_MUL_EN selects two's complement operands.
module mul_seq #(
  parameter int W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  mul_seq_if.slave   bus
);
  localparam int CW = $clog2(W + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [2*W-1:0] r_mcand;
  logic [W-1:0]   r_ysr;
  logic [2*W-1:0] r_acc;
  logic [CW-1:0]  r_cnt;
  logic [2*W-1:0] r_out;
  logic           r_done;

  logic           w_load;
  logic           w_step;
  logic           w_fin;
  logic           w_last;
  logic [2*W-1:0] w_pp;
  logic [2*W-1:0] w_acc_nxt;
  logic [2*W-1:0] w_mcand_init;

  assign w_last = (r_cnt == CW'(1));
  assign w_pp   = r_ysr[0] ? r_mcand : '0;

`ifdef SIGNED_MUL_EN
  // The multiplier MSB carries negative weight, so its partial product is subtracted.
  assign w_acc_nxt    = w_last ? (r_acc - w_pp) : (r_acc + w_pp);
  assign w_mcand_init = {{W{bus.x[W-1]}}, bus.x};
`else
  assign w_acc_nxt    = r_acc + w_pp;
  assign w_mcand_init = {{W{1'b0}}, bus.x};
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_fin       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = RUN;
          w_load      = 1'b1;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (w_last) begin
          w_state_nxt = IDLE;
          w_fin       = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_mcand <= '0;
      r_ysr   <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_fin;
      if (w_load) begin
        r_mcand <= w_mcand_init;
        r_ysr   <= bus.y;
        r_acc   <= '0;
        r_cnt   <= CW'(W);
      end else if (w_step) begin
        r_acc   <= w_acc_nxt;
        r_mcand <= r_mcand << 1;
        r_ysr   <= r_ysr >> 1;
        r_cnt   <= r_cnt - CW'(1);
      end
      // Result becomes visible only on the completing edge.
      if (w_fin) begin
        r_out <= w_acc_nxt;
      end
    end
  end

  assign bus.busy = (r_state == RUN);
  assign bus.done = r_done;
  assign bus.out  = r_out;
endmodule

// File: tb/tb_mul_seq.sv
// Scoreboarded bench for mul_seq at W=8 and W=2; expected products come from plain integer arithmetic.
module tb_mul_seq;
  typedef struct {
    longint unsigned p;
    int              c;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  exp_t q8[$];
  exp_t q2[$];
  longint unsigned last8 = 0;
  longint unsigned last2 = 0;

  mul_seq_if #(.W(8)) a8 ();
  mul_seq_if #(.W(2)) a2 ();

  mul_seq #(.W(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(a8));
  mul_seq #(.W(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(a2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint unsigned ref_mul(input int w, input longint unsigned xv, input longint unsigned yv);
    longint sx;
    longint sy;
    sx = longint'(xv);
    sy = longint'(yv);
`ifdef SIGNED_MUL_EN
    if (xv >= (64'd1 << (w - 1))) sx = sx - (longint'(1) << w);
    if (yv >= (64'd1 << (w - 1))) sy = sy - (longint'(1) << w);
`endif
    return longint'(sx * sy) & ((64'd1 << (2 * w)) - 1);
  endfunction

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: compare each done against the queue head, check latency and that out never moves otherwise.
  always @(negedge clk) begin
    if (!rst_n) begin
      last8 = 0;
    end else begin
      check("w8_busy_done_excl", 64'(a8.busy & a8.done), 0);
      if (a8.done) begin
        check("w8_done_expected", 64'(q8.size() > 0), 1);
        if (q8.size() > 0) begin
          exp_t e;
          e = q8.pop_front();
          check("w8_product", a8.out, e.p);
          check("w8_latency", 64'(cyc), 64'(e.c + 8));
        end
      end else begin
        check("w8_out_hold", a8.out, last8);
      end
      last8 = a8.out;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      last2 = 0;
    end else begin
      check("w2_busy_done_excl", 64'(a2.busy & a2.done), 0);
      if (a2.done) begin
        check("w2_done_expected", 64'(q2.size() > 0), 1);
        if (q2.size() > 0) begin
          exp_t e;
          e = q2.pop_front();
          check("w2_product", a2.out, e.p);
          check("w2_latency", 64'(cyc), 64'(e.c + 2));
        end
      end else begin
        check("w2_out_hold", a2.out, last2);
      end
      last2 = a2.out;
    end
  end

  // Drivers are called on a falling edge; an accept is predicted from busy, which is stable until the next rise.
  task automatic drv8(input logic s, input logic [7:0] xv, input logic [7:0] yv, output bit acc);
    a8.start = s;
    a8.x     = xv;
    a8.y     = yv;
    acc      = 1'b0;
    if (s && !a8.busy) begin
      q8.push_back('{p: ref_mul(8, 64'(xv), 64'(yv)), c: cyc + 1});
      acc = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic drv2(input logic s, input logic [1:0] xv, input logic [1:0] yv, output bit acc);
    a2.start = s;
    a2.x     = xv;
    a2.y     = yv;
    acc      = 1'b0;
    if (s && !a2.busy) begin
      q2.push_back('{p: ref_mul(2, 64'(xv), 64'(yv)), c: cyc + 1});
      acc = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle8(input int n);
    bit a;
    for (int k = 0; k < n; k++) drv8(1'b0, 8'd0, 8'd0, a);
  endtask

  task automatic op8(input logic [7:0] xv, input logic [7:0] yv);
    bit a;
    a = 1'b0;
    for (int k = 0; k < 40 && !a; k++) drv8(1'b1, xv, yv, a);
    check("w8_accept", 64'(a), 1);
    drv8(1'b0, 8'd0, 8'd0, a);
  endtask

  task automatic drain8();
    for (int k = 0; k < 40 && q8.size() > 0; k++) @(negedge clk);
    check("w8_drain", 64'(q8.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit a;
    a8.start = 1'b0; a8.x = '0; a8.y = '0;
    a2.start = 1'b0; a2.x = '0; a2.y = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(a8.busy), 0);
    check("rst_done", 64'(a8.done), 0);
    check("rst_out", a8.out, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Legacy equivalence: every W=2 operand pair, start held until accepted.
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = 4'(i);
      a = 1'b0;
      for (int k = 0; k < 10 && !a; k++) drv2(1'b1, v[3:2], v[1:0], a);
      check("w2_accept", 64'(a), 1);
    end
    drv2(1'b0, 2'd0, 2'd0, a);
    for (int k = 0; k < 10 && q2.size() > 0; k++) @(negedge clk);
    check("w2_drain", 64'(q2.size()), 0);

    // Full scale.
    op8(8'd255, 8'd255);
    drain8();
    idle8(2);

    // Handshake: starts at E3 and E8 must be ignored.
    op8(8'd3, 8'd5);
    idle8(1);
    drv8(1'b1, 8'd7, 8'd7, a);
    check("hs_e3_ignored", 64'(a), 0);
    idle8(4);
    drv8(1'b1, 8'd7, 8'd7, a);
    check("hs_e8_ignored", 64'(a), 0);
    idle8(12);
    check("hs_out_held", a8.out, 64'd15);
    check("w8_queue_empty", 64'(q8.size()), 0);

    // Back-to-back with start held high.
    drv8(1'b1, 8'd10, 8'd10, a);
    check("b2b_first_accept", 64'(a), 1);
    a = 1'b0;
    for (int k = 0; k < 20 && !a; k++) drv8(1'b1, 8'd12, 8'd2, a);
    check("b2b_second_accept", 64'(a), 1);
    idle8(1);
    drain8();

`ifdef SIGNED_MUL_EN
    op8(8'h80, 8'h80);
    drain8();
    op8(8'hFF, 8'h01);
    drain8();
    op8(8'h7F, 8'h80);
    drain8();
`endif

    // Reset mid-run aborts with no done pulse.
    op8(8'd200, 8'd77);
    idle8(2);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(a8.busy), 0);
    check("midrst_done", 64'(a8.done), 0);
    check("midrst_out", a8.out, 0);
    q8.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    idle8(15);
    check("midrst_out_after", a8.out, 0);

    // Randomized traffic, including operand changes while busy.
    for (int k = 0; k < 600; k++) begin
      drv8(($urandom_range(0, 2) == 0), 8'($urandom), 8'($urandom), a);
    end
    idle8(1);
    drain8();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
